ap_mult_err_eval: RTL and testbench

Exhaustive error-characterisation driver for the approximate 4-bit unsigned multiplier datapath. It sweeps every operand pair and generates the AND-array partial-product vector consumed by the compressor tree. It captures the tree's product back, compares it against the exact product, and accumulates error metrics for the evolutionary search loop. It is the producer and checker sitting on both ends of the compressor's `pp`/`res` interface.

---
 rtl/ap_mult_err_eval_pkg.sv | 20 ++
 rtl/ap_mult_err_eval_if.sv | 9 +
 rtl/ap_mult_err_eval_ppgen.sv | 12 +
 rtl/ap_mult_err_eval.sv | 107 ++++++++++
 tb/tb_ap_mult_err_eval.sv | 128 ++++++++++++
 5 files changed

// File: rtl/ap_mult_err_eval_pkg.sv
// ap_eval_pkg: state encoding and width helpers shared by the multiplier evaluator files
package ap_eval_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  function automatic int pp_w(int w);
    return w * w;
  endfunction
  function automatic int res_w(int w);
    return 2 * w;
  endfunction
  function automatic int n_pairs(int w);
    return 1 << (2 * w);
  endfunction
  function automatic int cnt_w(int w);
    return 2 * w + 1;
  endfunction
  function automatic int sum_w(int w);
    return 4 * w;
  endfunction
endpackage

// File: rtl/ap_mult_err_eval_if.sv
// ap_mult_err_eval_if: partial-product / product bus between the evaluator and the compressor tree
interface ap_mult_err_eval_if
  import ap_eval_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic [pp_w(WIDTH)-1:0] pp_o;
  logic [res_w(WIDTH)-1:0] res_i;
  modport master (output pp_o, input res_i);
  modport slave (input pp_o, output res_i);
endinterface

// File: rtl/ap_mult_err_eval_ppgen.sv
// ppgen: AND array producing the partial-product vector, bit WIDTH*i+j = a[j] & b[i]
module ppgen #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic [WIDTH*WIDTH-1:0] pp
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      assign pp[WIDTH*i+j] = a[j] & b[i];
    end
  end
endmodule

// File: rtl/ap_mult_err_eval.sv
// ap_mult_err_eval: sweeps all operand pairs through the compressor under test and accumulates error metrics
module ap_mult_err_eval
  import ap_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  ap_mult_err_eval_if.master        bus,
  output logic                      busy,
  output logic                      done,
  output logic [cnt_w(WIDTH)-1:0]   err_cnt,
  output logic [sum_w(WIDTH)-1:0]   sum_ed,
  output logic [res_w(WIDTH)-1:0]   max_ed,
  output logic [WIDTH-1:0]          worst_a,
  output logic [WIDTH-1:0]          worst_b
);
  localparam int PW = pp_w(WIDTH);
  localparam int RW = res_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam int SW = sum_w(WIDTH);
  localparam int TW = 1 + 2 * RW;
  state_t        state;
  logic [RW-1:0] n;
  logic          iss;
  logic [PW-1:0] pp;
  logic [TW-1:0] cur, tag;
  logic          tv, last;
  logic [RW-1:0] tn, tx, res, ed;
  ppgen #(.WIDTH(WIDTH)) u_ppgen (.a(n[WIDTH-1:0]), .b(n[RW-1:WIDTH]), .pp(pp));
  assign bus.pp_o = iss ? pp : '0;
  // tag = {valid, {b,a}, exact product} of the pair on the bus this cycle
  assign cur  = {iss, n, RW'(n[WIDTH-1:0]) * RW'(n[RW-1:WIDTH])};
  assign tv   = tag[TW-1];
  assign tn   = tag[TW-2 -: RW];
  assign tx   = tag[RW-1:0];
  assign res  = bus.res_i;
  assign ed   = res >= tx ? res - tx : tx - res;
  assign last = tv && tn == RW'(n_pairs(WIDTH) - 1);
  if (LAT == 0) begin : g_comb
    assign tag = cur;
  end else begin : g_pipe
    logic [TW-1:0] sh [LAT];
    // shift each issued tag alongside the tree pipeline so it meets its own res_i
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh <= '{default: '0};
      end else begin
        sh[0] <= cur;
        for (int k = 1; k < LAT; k++) sh[k] <= sh[k-1];
      end
    end
    assign tag = sh[LAT-1];
  end
  // control FSM, sweep counter and error accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n       <= '0;
      iss     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
      worst_a <= '0;
      worst_b <= '0;
    end else begin
      done <= 1'b0;
      if (iss) begin
        iss <= ~&n;
        n   <= n + 1'b1;
      end
      if (tv) begin
        err_cnt <= err_cnt + CW'(ed != '0);
        sum_ed  <= sum_ed + SW'(ed);
        if (ed > max_ed) begin
          max_ed  <= ed;
          worst_a <= tn[WIDTH-1:0];
          worst_b <= tn[RW-1:WIDTH];
        end
      end
      case (state)
        IDLE: if (start) begin
          state   <= SWEEP;
          busy    <= 1'b1;
          iss     <= 1'b1;
          n       <= '0;
          err_cnt <= '0;
          sum_ed  <= '0;
          max_ed  <= '0;
          worst_a <= '0;
          worst_b <= '0;
        end
        SWEEP: if (last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ap_mult_err_eval.sv
// tb_ap_mult_err_eval: directed sweeps against combinational and 2-stage compressor stubs
module tb_ap_mult_err_eval;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  int m0 = 0;
  int m2 = 0;
  int vec = 0;
  int err = 0;
  int d0, d2, c0, c2;
  logic busy0, done0, busy2, done2;
  logic [8:0] ec0, ec2;
  logic [15:0] se0, se2;
  logic [7:0] mx0, mx2, p1 = '0, p2 = '0;
  logic [3:0] wa0, wb0, wa2, wb2;
  ap_mult_err_eval_if #(.WIDTH(4)) bus0 ();
  ap_mult_err_eval_if #(.WIDTH(4)) bus2 ();
  ap_mult_err_eval #(.WIDTH(4), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0.master), .busy(busy0), .done(done0),
    .err_cnt(ec0), .sum_ed(se0), .max_ed(mx0), .worst_a(wa0), .worst_b(wb0));
  ap_mult_err_eval #(.WIDTH(4), .LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus2.master), .busy(busy2), .done(done2),
    .err_cnt(ec2), .sum_ed(se2), .max_ed(mx2), .worst_a(wa2), .worst_b(wb2));
  always #5 clk = ~clk;
  function automatic logic [7:0] prod(logic [15:0] p);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (p[4*i+j]) s = s + (8'd1 << (i + j));
    return s;
  endfunction
  assign bus0.res_i = m0 == 1 ? 8'd0 : prod(bus0.pp_o) + ((m0 == 2 && bus0.pp_o == 16'hFFFF) ? 8'd1 : 8'd0);
  always @(posedge clk) begin
    p1 <= prod(bus2.pp_o) + ((m2 == 1 && bus2.pp_o == 16'h0001) ? 8'd1 : 8'd0);
    p2 <= p1;
  end
  assign bus2.res_i = p2;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic res0(input string t, input int ec, input int se, input int mx, input int wa, input int wb);
    chk({t, "_err_cnt0"}, 32'(ec0), ec);
    chk({t, "_sum_ed0"}, 32'(se0), se);
    chk({t, "_max_ed0"}, 32'(mx0), mx);
    chk({t, "_worst_a0"}, 32'(wa0), wa);
    chk({t, "_worst_b0"}, 32'(wb0), wb);
  endtask
  task automatic res2(input string t, input int ec, input int se, input int mx, input int wa, input int wb);
    chk({t, "_err_cnt2"}, 32'(ec2), ec);
    chk({t, "_sum_ed2"}, 32'(se2), se);
    chk({t, "_max_ed2"}, 32'(mx2), mx);
    chk({t, "_worst_a2"}, 32'(wa2), wa);
    chk({t, "_worst_b2"}, 32'(wb2), wb);
  endtask
  task automatic zeros(input string t);
    chk({t, "_busy"}, {30'd0, busy0, busy2}, 0);
    chk({t, "_done"}, {30'd0, done0, done2}, 0);
    chk({t, "_pp"}, {bus0.pp_o, bus2.pp_o}, 0);
    res0(t, 0, 0, 0, 0, 0);
    res2(t, 0, 0, 0, 0, 0);
  endtask
  task automatic sweep(input int pa, input bit pd);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", {30'd0, busy0, busy2}, 3);
    chk("pp_n0", 32'(bus0.pp_o), 0);
    d0 = -1; d2 = -1; c0 = 0; c2 = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (done0 && d0 < 0) d0 = k;
      if (done2 && d2 < 0) d2 = k;
      c0 += int'(done0);
      c2 += int'(done2);
      if (k == 17) chk("pp_n17", 32'(bus0.pp_o), 32'h0001);
      if (k == 255) chk("pp_n255", 32'(bus0.pp_o), 32'hFFFF);
      if (k == 256) chk("pp_idle_after", 32'(bus0.pp_o), 0);
      start = (k == pa) || (pd && done0);
      if (d0 >= 0 && d2 >= 0 && k > d2 + 2) break;
    end
    start = 1'b0;
    chk("done0_edge", 32'(d0), 256);
    chk("done2_edge", 32'(d2), 258);
    chk("done0_width", 32'(c0), 1);
    chk("done2_width", 32'(c2), 1);
    chk("busy_after_done", {30'd0, busy0, busy2}, 0);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1 zeros("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    m0 = 0; m2 = 0;
    sweep(-1, 1'b0);
    res0("exact", 0, 0, 0, 0, 0);
    res2("exact", 0, 0, 0, 0, 0);
    m0 = 1; m2 = 1;
    sweep(-1, 1'b0);
    res0("zero_stub", 225, 14400, 225, 15, 15);
    res2("inject17", 1, 1, 1, 1, 1);
    m0 = 2; m2 = 0;
    sweep(100, 1'b1);
    res0("plus1_ignored_starts", 1, 1, 1, 15, 15);
    res2("exact_ignored_starts", 0, 0, 0, 0, 0);
    m0 = 1; m2 = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 zeros("midsweep_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    sweep(-1, 1'b0);
    res0("after_reset", 225, 14400, 225, 15, 15);
    res2("after_reset", 1, 1, 1, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
